// File: rtl/ofm_tx_stream.sv
// ofm_tx_stream: transmit-side output sequencer between the per-frame control
// and data FIFOs (first-word-fall-through) and the MAC transmit AXI-Stream port.
// One frame is streamed per descriptor. The delivered byte count is checked
// against the descriptor length, and a mismatch is flagged on tuser at tlast.
// Optional feature macro: OFM_TX_DROP_EN enables discarding of frames whose
// descriptor drop flag (bit 63) is set. If the macro is not defined, the flag
// is ignored and stat_tx_drop reads 0.
module ofm_tx_stream #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_KEEP_WIDTH = C_DATA_WIDTH / 8,
  parameter int C_LEN_WIDTH  = 16
) (
  input  logic                               tx_clk,
  input  logic                               tx_reset_n,
  input  logic [63:0]                        ctrl_fifo_rdata,
  input  logic                               ctrl_fifo_empty,
  output logic                               ctrl_fifo_rden,
  input  logic [C_DATA_WIDTH+C_KEEP_WIDTH:0] data_fifo_rdata,
  input  logic                               data_fifo_empty,
  output logic                               data_fifo_rden,
  output logic [C_DATA_WIDTH-1:0]            tx_axis_mac_tdata,
  output logic [C_KEEP_WIDTH-1:0]            tx_axis_mac_tkeep,
  output logic                               tx_axis_mac_tvalid,
  output logic                               tx_axis_mac_tlast,
  output logic                               tx_axis_mac_tuser,
  input  logic                               tx_axis_mac_tready,
  output logic                               frame_done,
  output logic [31:0]                        stat_tx_frames,
  output logic [31:0]                        stat_tx_err,
  output logic [31:0]                        stat_tx_drop
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2,
    ST_EOF  = 2'd3
  } state_t;

  state_t                   state;
  logic [C_LEN_WIDTH-1:0]   frame_len;
  logic [C_LEN_WIDTH-1:0]   byte_cnt;
  logic                     err_flag;

  logic [C_DATA_WIDTH-1:0]  fifo_data;
  logic [C_KEEP_WIDTH-1:0]  fifo_keep;
  logic                     fifo_last;
  logic [C_LEN_WIDTH:0]     byte_sum;
  logic [C_LEN_WIDTH-1:0]   byte_next;

  // Number of enabled bytes in one beat, sized to match the byte-count sum.
  function automatic logic [C_LEN_WIDTH:0] popcount(input logic [C_KEEP_WIDTH-1:0] keep);
    logic [C_LEN_WIDTH:0] cnt;
    cnt = {(C_LEN_WIDTH+1){1'b0}};
    for (int i = 0; i < C_KEEP_WIDTH; i++) begin
      cnt = cnt + {{C_LEN_WIDTH{1'b0}}, keep[i]};
    end
    return cnt;
  endfunction

  assign fifo_data = data_fifo_rdata[C_DATA_WIDTH-1:0];
  assign fifo_keep = data_fifo_rdata[C_DATA_WIDTH +: C_KEEP_WIDTH];
  assign fifo_last = data_fifo_rdata[C_DATA_WIDTH+C_KEEP_WIDTH];

  // Running byte count including the current beat; the extra bit catches overflow.
  assign byte_sum  = {1'b0, byte_cnt} + popcount(fifo_keep);
  assign byte_next = byte_sum[C_LEN_WIDTH] ? {C_LEN_WIDTH{1'b1}} : byte_sum[C_LEN_WIDTH-1:0];

  // Descriptor pop and retire pulse are decoded straight from the state register.
  assign ctrl_fifo_rden = (state == ST_EOF);
  assign frame_done     = (state == ST_EOF);

`ifdef OFM_TX_DROP_EN
  logic        drop_flag;
  logic [31:0] drop_cnt;
  logic        unused_ok;
  assign stat_tx_drop = drop_cnt;
  assign unused_ok    = ^ctrl_fifo_rdata[62:C_LEN_WIDTH];
`else
  logic        unused_ok;
  assign stat_tx_drop = 32'd0;
  assign unused_ok    = ^ctrl_fifo_rdata[63:C_LEN_WIDTH];
`endif

  // Zero-latency pass-through from the data FIFO to the MAC while streaming; drain-only while dropping.
  always_comb begin
    tx_axis_mac_tdata  = {C_DATA_WIDTH{1'b0}};
    tx_axis_mac_tkeep  = {C_KEEP_WIDTH{1'b0}};
    tx_axis_mac_tvalid = 1'b0;
    tx_axis_mac_tlast  = 1'b0;
    tx_axis_mac_tuser  = 1'b0;
    data_fifo_rden     = 1'b0;
    if (state == ST_DATA) begin
      tx_axis_mac_tdata  = fifo_data;
      tx_axis_mac_tkeep  = fifo_keep;
      tx_axis_mac_tlast  = fifo_last;
      tx_axis_mac_tvalid = ~data_fifo_empty;
      tx_axis_mac_tuser  = ~data_fifo_empty & fifo_last & (byte_sum != {1'b0, frame_len});
      data_fifo_rden     = ~data_fifo_empty & tx_axis_mac_tready;
    end else if (state == ST_DROP) begin
      data_fifo_rden     = ~data_fifo_empty;
    end else begin
      data_fifo_rden     = 1'b0;
    end
  end

  // Frame sequencer: latch descriptor, stream or drop beats, retire and count the frame.
  always_ff @(posedge tx_clk or negedge tx_reset_n) begin
    if (!tx_reset_n) begin
      state          <= ST_IDLE;
      frame_len      <= {C_LEN_WIDTH{1'b0}};
      byte_cnt       <= {C_LEN_WIDTH{1'b0}};
      err_flag       <= 1'b0;
      stat_tx_frames <= 32'd0;
      stat_tx_err    <= 32'd0;
`ifdef OFM_TX_DROP_EN
      drop_flag      <= 1'b0;
      drop_cnt       <= 32'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!ctrl_fifo_empty) begin
            frame_len <= ctrl_fifo_rdata[C_LEN_WIDTH-1:0];
            byte_cnt  <= {C_LEN_WIDTH{1'b0}};
            err_flag  <= 1'b0;
`ifdef OFM_TX_DROP_EN
            drop_flag <= ctrl_fifo_rdata[63];
            state     <= ctrl_fifo_rdata[63] ? ST_DROP : ST_DATA;
`else
            state     <= ST_DATA;
`endif
          end
        end
        ST_DATA: begin
          if (data_fifo_rden) begin
            byte_cnt <= byte_next;
            if (fifo_last) begin
              err_flag <= tx_axis_mac_tuser;
              state    <= ST_EOF;
            end
          end
        end
        ST_DROP: begin
          if (data_fifo_rden && fifo_last) begin
            state <= ST_EOF;
          end
        end
        ST_EOF: begin
`ifdef OFM_TX_DROP_EN
          if (drop_flag) begin
            drop_cnt <= drop_cnt + 32'd1;
          end else if (err_flag) begin
            stat_tx_err <= stat_tx_err + 32'd1;
          end else begin
            stat_tx_frames <= stat_tx_frames + 32'd1;
          end
`else
          if (err_flag) begin
            stat_tx_err <= stat_tx_err + 32'd1;
          end else begin
            stat_tx_frames <= stat_tx_frames + 32'd1;
          end
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_tx_stream.sv
// Testbench for ofm_tx_stream (C_DATA_WIDTH=64). The bench owns both FIFOs as
// queues, keeps a frame-level scoreboard of expected beats and outcomes, and
// compares the MAC stream and statistics on every falling clock edge.
module tb_ofm_tx_stream;

`ifdef OFM_TX_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        tx_clk;
  logic        tx_reset_n;
  logic [63:0] ctrl_fifo_rdata;
  logic        ctrl_fifo_empty;
  logic        ctrl_fifo_rden;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_empty;
  logic        data_fifo_rden;
  logic [63:0] tx_axis_mac_tdata;
  logic [7:0]  tx_axis_mac_tkeep;
  logic        tx_axis_mac_tvalid;
  logic        tx_axis_mac_tlast;
  logic        tx_axis_mac_tuser;
  logic        tx_axis_mac_tready;
  logic        frame_done;
  logic [31:0] stat_tx_frames;
  logic [31:0] stat_tx_err;
  logic [31:0] stat_tx_drop;

  ofm_tx_stream #(.C_DATA_WIDTH(64), .C_LEN_WIDTH(16)) dut (
    .tx_clk             (tx_clk),
    .tx_reset_n         (tx_reset_n),
    .ctrl_fifo_rdata    (ctrl_fifo_rdata),
    .ctrl_fifo_empty    (ctrl_fifo_empty),
    .ctrl_fifo_rden     (ctrl_fifo_rden),
    .data_fifo_rdata    (data_fifo_rdata),
    .data_fifo_empty    (data_fifo_empty),
    .data_fifo_rden     (data_fifo_rden),
    .tx_axis_mac_tdata  (tx_axis_mac_tdata),
    .tx_axis_mac_tkeep  (tx_axis_mac_tkeep),
    .tx_axis_mac_tvalid (tx_axis_mac_tvalid),
    .tx_axis_mac_tlast  (tx_axis_mac_tlast),
    .tx_axis_mac_tuser  (tx_axis_mac_tuser),
    .tx_axis_mac_tready (tx_axis_mac_tready),
    .frame_done         (frame_done),
    .stat_tx_frames     (stat_tx_frames),
    .stat_tx_err        (stat_tx_err),
    .stat_tx_drop       (stat_tx_drop)
  );

  // FIFO contents and scoreboard
  logic [63:0] ctrl_q[$];
  logic [72:0] data_q[$];
  logic [81:0] exp_beat_q[$];   // {id, data, keep, last, tuser}
  logic [9:0]  exp_out_q[$];    // {id, kind}: 0 good, 1 err, 2 drop
  logic [31:0] m_frames, m_err, m_drop;
  logic [7:0]  next_id;

  int checks, errors;
  int cyc, valid_cycles, stall_cycles, accepted, dpops, ctrl_pulses;
  int first_acc, last_cyc, done_cyc;
  logic [7:0] last_keep;
  logic       last_tuser;
  bit         ready_mode;
  bit         pop_c, pop_d;
  bit         prev_stall;
  logic [72:0] prev_beat;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic refresh_fifo();
    ctrl_fifo_empty = (ctrl_q.size() == 0);
    ctrl_fifo_rdata = ctrl_fifo_empty ? 64'd0 : ctrl_q[0];
    data_fifo_empty = (data_q.size() == 0);
    data_fifo_rdata = data_fifo_empty ? 73'd0 : data_q[0];
  endtask

  // Clock, FIFO pops (requests sampled 1ns before the rising edge) and tready pattern
  initial begin
    tx_clk = 1'b0;
    forever begin
      #4;
      pop_c = ctrl_fifo_rden;
      pop_d = data_fifo_rden;
      #1 tx_clk = 1'b1;
      #1;
      if (pop_c && ctrl_q.size() > 0) void'(ctrl_q.pop_front());
      if (pop_d && data_q.size() > 0) begin
        void'(data_q.pop_front());
        dpops++;
      end
      refresh_fifo();
      #1 tx_axis_mac_tready = ready_mode ? ~tx_axis_mac_tready : 1'b1;
      #3 tx_clk = 1'b0;
    end
  end

  // Compare process: stream against scoreboard, stats against the frame-level model
  always @(negedge tx_clk) begin
    logic [81:0] e;
    logic [9:0]  o;
    cyc++;
    if (tx_reset_n) begin
      chk("rden_vs_done", ctrl_fifo_rden, frame_done);
      chk("stat_frames", stat_tx_frames, m_frames);
      chk("stat_err", stat_tx_err, m_err);
      chk("stat_drop", stat_tx_drop, m_drop);
      if (!tx_axis_mac_tvalid) chk("tuser_idle", tx_axis_mac_tuser, 1'b0);
      if (prev_stall) begin
        chk("hold_valid", tx_axis_mac_tvalid, 1'b1);
        chk("hold_beat", {tx_axis_mac_tlast, tx_axis_mac_tkeep, tx_axis_mac_tdata}, prev_beat);
      end
      if (tx_axis_mac_tvalid) valid_cycles++;
      if (tx_axis_mac_tvalid && !tx_axis_mac_tready) stall_cycles++;
      if (tx_axis_mac_tvalid && tx_axis_mac_tready) begin
        chk("beat_expected", exp_beat_q.size() != 0, 1'b1);
        if (exp_beat_q.size() != 0) begin
          e = exp_beat_q.pop_front();
          chk("beat", {tx_axis_mac_tdata, tx_axis_mac_tkeep, tx_axis_mac_tlast, tx_axis_mac_tuser}, e[73:0]);
          if (accepted == 0) first_acc = cyc;
          accepted++;
          if (tx_axis_mac_tlast) begin
            last_cyc   = cyc;
            last_keep  = tx_axis_mac_tkeep;
            last_tuser = tx_axis_mac_tuser;
          end
        end
      end
      if (frame_done) begin
        done_cyc = cyc;
        ctrl_pulses++;
        chk("frame_expected", exp_out_q.size() != 0, 1'b1);
        if (exp_out_q.size() != 0) begin
          o = exp_out_q.pop_front();
          chk("no_leftover", (exp_beat_q.size() > 0) && (exp_beat_q[0][81:74] == o[9:2]), 1'b0);
          case (o[1:0])
            2'd0:    m_frames = m_frames + 32'd1;
            2'd1:    m_err    = m_err + 32'd1;
            default: m_drop   = m_drop + 32'd1;
          endcase
        end
      end
      prev_stall = tx_axis_mac_tvalid && !tx_axis_mac_tready;
      prev_beat  = {tx_axis_mac_tlast, tx_axis_mac_tkeep, tx_axis_mac_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge tx_clk);
    #3;
  endtask

  task automatic clear_counts();
    valid_cycles = 0; stall_cycles = 0; accepted = 0; dpops = 0; ctrl_pulses = 0;
  endtask

  // Queue one descriptor and its beats; gap > 0 trickles beats in to exercise stalls
  task automatic send_frame(input logic [15:0] len, input int nbytes, input bit drop, input int gap);
    logic [7:0]  id;
    logic [63:0] d;
    logic [7:0]  k;
    int nb, rem, b;
    bit bad, dropped, last;
    id = next_id;
    next_id = next_id + 8'd1;
    nb = (nbytes + 7) / 8;
    bad = (nbytes != int'(len));
    dropped = drop & DROP_EN;
    exp_out_q.push_back({id, dropped ? 2'd2 : (bad ? 2'd1 : 2'd0)});
    ctrl_q.push_back({drop, 47'd0, len});
    refresh_fifo();
    rem = nbytes;
    for (int i = 0; i < nb; i++) begin
      b = (rem > 8) ? 8 : rem;
      rem = rem - b;
      k = 8'((16'd1 << b) - 16'd1);
      d = {id, 24'h5A5A5A, 32'(i)};
      last = (i == nb - 1);
      if (gap > 0) repeat (gap) tick();
      data_q.push_back({last, k, d});
      if (!dropped) exp_beat_q.push_back({id, d, k, last, last & bad});
      refresh_fifo();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_out_q.size() != 0 || ctrl_q.size() != 0) && n < 600) begin
      tick();
      n++;
    end
    chk("idle_reached", exp_out_q.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    m_frames = 32'd0; m_err = 32'd0; m_drop = 32'd0; next_id = 8'd1;
    ready_mode = 1'b0; tx_axis_mac_tready = 1'b1; prev_stall = 1'b0;
    tx_reset_n = 1'b0;
    refresh_fifo();
    clear_counts();
    repeat (3) tick();
    chk("rst_tvalid", tx_axis_mac_tvalid, 1'b0);
    chk("rst_frames", stat_tx_frames, 32'd0);
    tx_reset_n = 1'b1;
    tick();
    chk("idle_outputs", {tx_axis_mac_tvalid, ctrl_fifo_rden, data_fifo_rden, frame_done}, 4'b0000);

    // 1: 100-byte frame, MAC always ready
    clear_counts();
    send_frame(16'd100, 100, 1'b0, 0);
    wait_idle();
    chk("t1_beats", accepted, 13);
    chk("t1_valid_cycles", valid_cycles, 13);
    chk("t1_contiguous", last_cyc - first_acc, 12);
    chk("t1_done_delay", done_cyc - last_cyc, 1);
    chk("t1_last_keep", last_keep, 8'h0F);
    chk("t1_last_tuser", last_tuser, 1'b0);
    chk("t1_frames", stat_tx_frames, 32'd1);

    // 2: same frame with tready toggling, first DATA cycle not ready
    ready_mode = 1'b1;
    tick();
    while (tx_axis_mac_tready !== 1'b1) tick();
    clear_counts();
    send_frame(16'd100, 100, 1'b0, 0);
    wait_idle();
    ready_mode = 1'b0;
    chk("t2_beats", accepted, 13);
    chk("t2_valid_cycles", valid_cycles, 26);
    chk("t2_stalls", stall_cycles, 13);
    chk("t2_frames", stat_tx_frames, 32'd2);

    // 3: length mismatches in both directions
    clear_counts();
    send_frame(16'd96, 100, 1'b0, 0);
    wait_idle();
    chk("t3a_tuser", last_tuser, 1'b1);
    chk("t3a_err", stat_tx_err, 32'd1);
    send_frame(16'd104, 100, 1'b0, 0);
    wait_idle();
    chk("t3b_tuser", last_tuser, 1'b1);
    chk("t3b_err", stat_tx_err, 32'd2);
    chk("t3_frames", stat_tx_frames, 32'd2);

    // 4: one-beat frame
    clear_counts();
    send_frame(16'd5, 5, 1'b0, 0);
    wait_idle();
    chk("t4_valid_cycles", valid_cycles, 1);
    chk("t4_keep", last_keep, 8'h1F);
    chk("t4_done_delay", done_cyc - last_cyc, 1);

    // 5: drop-flagged 5-beat frame followed by a normal frame
    clear_counts();
    send_frame(16'd40, 40, 1'b1, 0);
    wait_idle();
    chk("t5_pops", dpops, 5);
`ifdef OFM_TX_DROP_EN
    chk("t5_no_valid", valid_cycles, 0);
    chk("t5_drop", stat_tx_drop, 32'd1);
`else
    chk("t5_streamed", accepted, 5);
    chk("t5_drop_zero", stat_tx_drop, 32'd0);
`endif
    clear_counts();
    send_frame(16'd24, 24, 1'b0, 0);
    wait_idle();
    chk("t5_second", accepted, 3);

    // 6: starved data FIFO mid-frame is a stall, not an error
    clear_counts();
    send_frame(16'd30, 30, 1'b0, 3);
    wait_idle();
    chk("t6_beats", accepted, 4);
    chk("t6_tuser", last_tuser, 1'b0);
    chk("t6_err", stat_tx_err, 32'd2);

    // 7: reset during beat 3 of 8
    clear_counts();
    send_frame(16'd64, 64, 1'b0, 0);
    begin
      int n;
      n = 0;
      while (accepted < 2 && n < 100) begin tick(); n++; end
    end
    chk("t7_at_beat3", tx_axis_mac_tvalid, 1'b1);
    tx_reset_n = 1'b0;
    #1;
    chk("t7_outputs_zero", {tx_axis_mac_tdata, tx_axis_mac_tkeep, tx_axis_mac_tvalid, tx_axis_mac_tlast,
                            tx_axis_mac_tuser, ctrl_fifo_rden, data_fifo_rden, frame_done}, 78'd0);
    chk("t7_stats_zero", {stat_tx_frames, stat_tx_err, stat_tx_drop}, 96'd0);
    ctrl_q.delete(); data_q.delete(); exp_beat_q.delete(); exp_out_q.delete();
    m_frames = 32'd0; m_err = 32'd0; m_drop = 32'd0;
    refresh_fifo();
    repeat (3) tick();
    tx_reset_n = 1'b1;
    repeat (3) tick();
    chk("t7_no_ctrl_pop", ctrl_pulses, 0);
    chk("t7_idle_valid", tx_axis_mac_tvalid, 1'b0);
    chk("t7_frames_zero", stat_tx_frames, 32'd0);

    // 8: frame counter wraps
    m_frames = 32'hFFFF_FFFF;
    force dut.stat_tx_frames = 32'hFFFF_FFFF;
    #1;
    release dut.stat_tx_frames;
    tick();
    chk("t8_preload", stat_tx_frames, 32'hFFFF_FFFF);
    send_frame(16'd16, 16, 1'b0, 0);
    wait_idle();
    chk("t8_wrapped", stat_tx_frames, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
